seg7_bin_display: RTL and testbench

SEG7_BIN_DISPLAY -- requirements
Module: seg7_bin_display

---
 rtl/seg7_bin_display.sv | 180 ++++++++++++++++++
 tb/tb_seg7_bin_display.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_bin_display.sv
// Binary to multi-digit 7-segment display driver: a serial double-dabble conversion
// (one input bit per cycle) followed by a registered segment encode with leading-zero blanking.
module seg7_bin_display #(
    parameter int DIGITS     = 4,
    parameter int WIDTH      = 14,
    parameter int ACTIVE_LOW = 1,
    parameter int BLANK_LZ   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic [7*DIGITS-1:0]   seg,
    output logic                  busy,
    output logic                  done,
    output logic                  ovf
);

    localparam int         BW         = 4 * DIGITS;
    localparam logic [5:0] LAST_STEP  = 6'(WIDTH - 1);
    localparam logic [6:0] BLANK_CODE = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [6:0] DASH_CODE  = (ACTIVE_LOW != 0) ? 7'h3F : 7'h40;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        ENC  = 2'd2
    } state_t;

    function automatic logic [6:0] digit_code(input logic [3:0] d);
        logic [6:0] code_al;
        case (d)
            4'd0:    code_al = 7'h40;
            4'd1:    code_al = 7'h79;
            4'd2:    code_al = 7'h24;
            4'd3:    code_al = 7'h30;
            4'd4:    code_al = 7'h19;
            4'd5:    code_al = 7'h12;
            4'd6:    code_al = 7'h02;
            4'd7:    code_al = 7'h78;
            4'd8:    code_al = 7'h00;
            4'd9:    code_al = 7'h10;
            default: code_al = 7'h7F;
        endcase
        if (ACTIVE_LOW != 0) begin
            digit_code = code_al;
        end else begin
            digit_code = ~code_al;
        end
    endfunction

    state_t               state_q, state_d;
    logic [5:0]           cnt_q, cnt_d;
    logic [WIDTH-1:0]     shreg_q, shreg_d;
    logic [BW-1:0]        bcd_q, bcd_d;
    logic                 of_q, of_d;
    logic [7*DIGITS-1:0]  seg_q, seg_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 ovf_q, ovf_d;
    logic [BW-1:0]        adj_s;
    logic [7*DIGITS-1:0]  seg_s;

    // Double-dabble correction: add 3 to every nibble of 5 or more before the shift.
    always_comb begin
        adj_s = bcd_q;
        for (int k = 0; k < DIGITS; k++) begin
            if (bcd_q[4*k +: 4] >= 4'd5) begin
                adj_s[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
            end else begin
                adj_s[4*k +: 4] = bcd_q[4*k +: 4];
            end
        end
    end

    // Segment encode from the top digit down so leading zeros can be tracked.
    always_comb begin
        logic       lead;
        logic [3:0] d;
        seg_s = '0;
        lead  = 1'b1;
        d     = 4'd0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            d = bcd_q[4*k +: 4];
            if (of_q) begin
                seg_s[7*k +: 7] = DASH_CODE;
            end else if ((BLANK_LZ != 0) && lead && (d == 4'd0) && (k != 0)) begin
                seg_s[7*k +: 7] = BLANK_CODE;
            end else begin
                seg_s[7*k +: 7] = digit_code(d);
            end
            if (d != 4'd0) begin
                lead = 1'b0;
            end else begin
                lead = lead;
            end
        end
    end

    // Next-state and datapath updates for the IDLE/CONV/ENC sequence.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        bcd_d   = bcd_q;
        of_d    = of_q;
        seg_d   = seg_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CONV;
                    shreg_d = bin;
                    bcd_d   = '0;
                    of_d    = 1'b0;
                    cnt_d   = 6'd0;
                    busy_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            CONV: begin
                // The bit leaving the top of the BCD register means the value no longer fits.
                bcd_d   = {adj_s[BW-2:0], shreg_q[WIDTH-1]};
                of_d    = of_q | adj_s[BW-1];
                shreg_d = shreg_q << 1;
                cnt_d   = cnt_q + 6'd1;
                if (cnt_q == LAST_STEP) begin
                    state_d = ENC;
                end else begin
                    state_d = CONV;
                end
            end
            ENC: begin
                seg_d   = seg_s;
                ovf_d   = of_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 6'd0;
            shreg_q <= '0;
            bcd_q   <= '0;
            of_q    <= 1'b0;
            seg_q   <= {DIGITS{BLANK_CODE}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            bcd_q   <= bcd_d;
            of_q    <= of_d;
            seg_q   <= seg_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
        end
    end

    assign seg  = seg_q;
    assign busy = busy_q;
    assign done = done_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_seg7_bin_display.sv
// Randomized self-checking bench for seg7_bin_display: default, no-blanking and
// active-high 2-digit instances checked against a decimal arithmetic reference model.
module tb_seg7_bin_display;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [13:0] bin = 14'd0;
    logic [27:0] seg, seg_nb;
    logic        busy, done, ovf, busy_nb, done_nb, ovf_nb;
    logic        start_al = 1'b0;
    logic [7:0]  bin_al = 8'd0;
    logic [13:0] seg_al;
    logic        busy_al, done_al, ovf_al;

    int n_cmp = 0;
    int n_fail = 0;

    logic [6:0] enc_tab [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                  7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    seg7_bin_display dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bin(bin),
        .seg(seg), .busy(busy), .done(done), .ovf(ovf));

    seg7_bin_display #(.BLANK_LZ(0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .start(start), .bin(bin),
        .seg(seg_nb), .busy(busy_nb), .done(done_nb), .ovf(ovf_nb));

    seg7_bin_display #(.DIGITS(2), .WIDTH(8), .ACTIVE_LOW(0)) dut_al (
        .clk(clk), .rst_n(rst_n), .start(start_al), .bin(bin_al),
        .seg(seg_al), .busy(busy_al), .done(done_al), .ovf(ovf_al));

    always #5 clk = ~clk;

    // Reference: decimal digits by division, blank above the leading digit, dashes on overflow.
    function automatic logic [55:0] model_seg(input longint v, input int digits,
                                              input bit al, input bit blz);
        logic [55:0] r;
        logic [6:0]  c;
        longint      p, pk;
        int          d;
        r = '0;
        p = 1;
        for (int i = 0; i < digits; i++) p = p * 10;
        pk = 1;
        for (int k = 0; k < digits; k++) begin
            d = int'((v / pk) % 10);
            if (v >= p) c = 7'h3F;
            else if (blz && k > 0 && v < pk) c = 7'h7F;
            else c = enc_tab[d];
            if (!al) c = ~c;
            r[7*k +: 7] = c;
            pk = pk * 10;
        end
        return r;
    endfunction

    task automatic run_conv(input int value);
        logic [55:0] m;
        logic [27:0] exp_s, exp_nb, held;
        logic        exp_o;
        int          n;
        bit          seen;
        m = model_seg(value, 4, 1'b1, 1'b1); exp_s = m[27:0];
        m = model_seg(value, 4, 1'b1, 1'b0); exp_nb = m[27:0];
        exp_o = (value >= 10000);
        start = 1'b1;
        bin = 14'(value);
        @(posedge clk); #1;
        start = 1'b0;
        bin = 14'($urandom_range(0, 16383));
        n_cmp++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_on v=%0d: got %b expected 1", value, busy); end
        seen = 1'b0;
        n = 0;
        while (!seen && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (done === 1'b1) seen = 1'b1;
            else begin
                n_cmp++;
                if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_hold v=%0d cyc=%0d: got %b expected 1", value, n, busy); end
            end
        end
        n_cmp++;
        if (!seen || n != 15) begin n_fail++; $display("FAIL latency v=%0d: got %0d cycles (seen=%0d) expected 15", value, n, seen); end
        n_cmp++;
        if (seg !== exp_s) begin n_fail++; $display("FAIL seg v=%0d: got %h expected %h", value, seg, exp_s); end
        n_cmp++;
        if (ovf !== exp_o) begin n_fail++; $display("FAIL ovf v=%0d: got %b expected %b", value, ovf, exp_o); end
        n_cmp++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_off v=%0d: got %b expected 0", value, busy); end
        n_cmp++;
        if (seg_nb !== exp_nb || ovf_nb !== exp_o || done_nb !== 1'b1) begin
            n_fail++; $display("FAIL seg_nolz v=%0d: got %h/%b/%b expected %h/%b/1", value, seg_nb, ovf_nb, done_nb, exp_nb, exp_o);
        end
        held = seg;
        @(posedge clk); #1;
        n_cmp++;
        if (done !== 1'b0 || seg !== exp_s) begin
            n_fail++; $display("FAIL done_pulse v=%0d: got done=%b seg=%h expected done=0 seg=%h", value, done, seg, exp_s);
        end
    endtask

    task automatic run_al(input int value);
        logic [55:0] m;
        logic [13:0] exp_s;
        int          n;
        bit          seen;
        m = model_seg(value, 2, 1'b0, 1'b1); exp_s = m[13:0];
        start_al = 1'b1;
        bin_al = 8'(value);
        @(posedge clk); #1;
        start_al = 1'b0;
        seen = 1'b0;
        n = 0;
        while (!seen && n < 30) begin
            @(posedge clk); #1;
            n++;
            if (done_al === 1'b1) seen = 1'b1;
        end
        n_cmp++;
        if (!seen || n != 9) begin n_fail++; $display("FAIL al_latency v=%0d: got %0d expected 9", value, n); end
        n_cmp++;
        if (seg_al !== exp_s || ovf_al !== (value >= 100)) begin
            n_fail++; $display("FAIL al_seg v=%0d: got %h/%b expected %h/%b", value, seg_al, ovf_al, exp_s, value >= 100);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (seg !== {4{7'h7F}} || busy !== 1'b0 || done !== 1'b0 || ovf !== 1'b0) begin
            n_fail++; $display("FAIL reset: got seg=%h busy=%b done=%b ovf=%b expected %h/0/0/0", seg, busy, done, ovf, {4{7'h7F}});
        end
        n_cmp++;
        if (seg_al !== 14'h0000 || busy_al !== 1'b0) begin
            n_fail++; $display("FAIL reset_al: got seg=%h busy=%b expected 0000/0", seg_al, busy_al);
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_vectors();
        run_conv(1234);
        run_conv(7);
        run_conv(0);
        run_conv(9999);
        run_conv(10000);
        run_conv(16383);
    endtask

    task automatic test_random();
        for (int i = 0; i < 12; i++) run_conv(int'($urandom_range(0, 16383)));
    endtask

    task automatic test_back_to_back();
        int          acc_q[$];
        int          exp_done[$];
        int          next_free, ndone, v;
        logic [55:0] m;
        logic [27:0] exp_s;
        next_free = 0;
        ndone = 0;
        for (int c = 0; c < 48; c++) begin
            bin = 14'($urandom_range(0, 16383));
            start = (c < 32);
            if (start && c >= next_free) begin
                acc_q.push_back(int'(bin));
                exp_done.push_back(c + 15);
                next_free = c + 16;
            end
            @(posedge clk); #1;
            if (done === 1'b1) begin
                ndone++;
                n_cmp++;
                if (exp_done.size() == 0) begin
                    n_fail++; $display("FAIL b2b_extra_done: got done at %0d expected none", c);
                end else begin
                    v = acc_q.pop_front();
                    m = model_seg(v, 4, 1'b1, 1'b1);
                    exp_s = m[27:0];
                    if (c != exp_done[0] || seg !== exp_s) begin
                        n_fail++; $display("FAIL b2b_done v=%0d: got cyc=%0d seg=%h expected cyc=%0d seg=%h", v, c, seg, exp_done[0], exp_s);
                    end
                    void'(exp_done.pop_front());
                end
            end
        end
        start = 1'b0;
        n_cmp++;
        if (ndone != 2 || exp_done.size() != 0) begin
            n_fail++; $display("FAIL b2b_count: got %0d done pulses expected 2", ndone);
        end
    endtask

    task automatic test_reset_midconv();
        int nd;
        start = 1'b1;
        bin = 14'($urandom_range(0, 16383));
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (seg !== {4{7'h7F}} || busy !== 1'b0 || done !== 1'b0 || ovf !== 1'b0) begin
            n_fail++; $display("FAIL midreset: got seg=%h busy=%b done=%b ovf=%b expected %h/0/0/0", seg, busy, done, ovf, {4{7'h7F}});
        end
        nd = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (done === 1'b1) nd++;
        end
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #2;
            if (done === 1'b1) nd++;
        end
        n_cmp++;
        if (nd != 0) begin n_fail++; $display("FAIL midreset_done: got %0d pulses expected 0", nd); end
        @(negedge clk);
        run_conv(42);
    endtask

    task automatic test_active_high();
        run_al(255);
        run_al(99);
        run_al(100);
        run_al(5);
        run_al(0);
        for (int i = 0; i < 6; i++) run_al(int'($urandom_range(0, 255)));
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_random();
        test_back_to_back();
        @(posedge clk); #1;
        test_reset_midconv();
        test_active_high();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
